// File: rtl/pair_accum.sv
// pair_accum: streams even/odd word pairs from a dual-port RAM and
// accumulates their sum, pair count and (optionally) the largest word.
//
// Ports:
//   clk, reset (async, active-low), start
//   addr_a/addr_b       : even/odd address pair from the upstream counter
//   rd_data_a/rd_data_b : RAM read data, one cycle after mem_rd_en
//   mem_addr_a/b, mem_rd_en : RAM port addresses and shared read strobe
//   sum, pair_count, max_val, max_addr : pass results
//   busy, done, err     : status (err is sticky for the pass)
//
// Build option: define PAIR_ACCUM_MAX_EN to include max tracking;
// otherwise max_val/max_addr read as zero.

module pair_accum #(
    parameter int          DATA_W   = 16,
    parameter logic [13:0] END_ADDR = 14'd13312
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [13:0]       addr_a,
    input  logic [13:0]       addr_b,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    output logic [13:0]       mem_addr_a,
    output logic [13:0]       mem_addr_b,
    output logic              mem_rd_en,
    output logic [31:0]       sum,
    output logic [DATA_W-1:0] max_val,
    output logic [13:0]       max_addr,
    output logic [9:0]        pair_count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  r_state;
    logic        r_rd_vld;
    logic [31:0] r_sum;
    logic [9:0]  r_cnt;
    logic        r_err;

    logic        w_run;
    logic        w_in_range;
    logic        w_pair_ok;
    logic        w_start_ok;
    logic [13:0] w_addr_a_p1;

    assign w_addr_a_p1 = addr_a + 14'd1;
    assign w_run       = (r_state == S_RUN);
    assign w_in_range  = (addr_a < END_ADDR);
    assign w_pair_ok   = !addr_a[0] && (addr_b == w_addr_a_p1);
    // start is only honoured from the two quiescent states
    assign w_start_ok  = start &&
                         ((r_state == S_IDLE) || (r_state == S_DONE));

    assign mem_addr_a  = addr_a;
    assign mem_addr_b  = addr_b;
    assign mem_rd_en   = w_run && w_in_range && w_pair_ok;

    assign sum         = r_sum;
    assign pair_count  = r_cnt;
    assign err         = r_err;
    assign busy        = w_run || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE,
                S_DONE:  if (start) r_state <= S_RUN;
                S_RUN:   if (!w_in_range) r_state <= S_DRAIN;
                S_DRAIN: r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_vld <= 1'b0;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else if (w_start_ok) begin
            r_rd_vld <= 1'b0;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rd_vld <= mem_rd_en;
            if (r_rd_vld) begin
                r_sum <= r_sum + 32'(rd_data_a) + 32'(rd_data_b);
                r_cnt <= r_cnt + 10'd1;
            end
            // malformed pair inside the window: skip it and flag
            if (w_run && w_in_range && !w_pair_ok)
                r_err <= 1'b1;
        end
    end

`ifdef PAIR_ACCUM_MAX_EN
    logic [13:0]       r_addr_a_q;
    logic [13:0]       r_addr_b_q;
    logic [DATA_W-1:0] r_max_val;
    logic [13:0]       r_max_addr;
    logic              w_pick_a;
    logic [DATA_W-1:0] w_cand;
    logic [13:0]       w_cand_addr;

    // ties go to the even word, so the lower address wins
    assign w_pick_a    = (rd_data_a >= rd_data_b);
    assign w_cand      = w_pick_a ? rd_data_a : rd_data_b;
    assign w_cand_addr = w_pick_a ? r_addr_a_q : r_addr_b_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr_a_q <= '0;
            r_addr_b_q <= '0;
            r_max_val  <= '0;
            r_max_addr <= '0;
        end else if (w_start_ok) begin
            r_addr_a_q <= '0;
            r_addr_b_q <= '0;
            r_max_val  <= '0;
            r_max_addr <= '0;
        end else begin
            r_addr_a_q <= addr_a;
            r_addr_b_q <= addr_b;
            // strict compare keeps the earliest address on equal values
            if (r_rd_vld && (w_cand > r_max_val)) begin
                r_max_val  <= w_cand;
                r_max_addr <= w_cand_addr;
            end
        end
    end

    assign max_val  = r_max_val;
    assign max_addr = r_max_addr;
`else
    assign max_val  = '0;
    assign max_addr = '0;
`endif

endmodule

// File: tb/tb_pair_accum.sv
// tb_pair_accum: directed passes over a behavioural dual-port RAM;
// a scoreboard queue holds hand-computed per-pass results.

module tb_pair_accum;

    localparam int DW  = 16;
    localparam int END = 13312;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [13:0]   addr_a, addr_b;
    logic [DW-1:0] rd_data_a, rd_data_b;
    logic [13:0]   mem_addr_a, mem_addr_b;
    logic          mem_rd_en;
    logic [31:0]   sum;
    logic [DW-1:0] max_val;
    logic [13:0]   max_addr;
    logic [9:0]    pair_count;
    logic          busy, done, err;

    pair_accum dut (
        .clk(clk), .reset(reset), .start(start),
        .addr_a(addr_a), .addr_b(addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
        .mem_rd_en(mem_rd_en), .sum(sum),
        .max_val(max_val), .max_addr(max_addr),
        .pair_count(pair_count), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int cnt;
        int mx;
        int mxa;
        int err;
        int cyc;
        int rden;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   mode     = 0;

    task automatic chk(input string nm, input longint act,
                       input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic logic [DW-1:0] word(input logic [13:0] a);
        logic [DW-1:0] w;
        w = '0;
        case (mode)
            0: w = DW'(a[7:0]);
            1: if (a == 14'd12800 || a == 14'd12801) w = 16'hBEEF;
            default: begin
                if (a == 14'd12289 || a == 14'd12400 ||
                    a == 14'd12500) w = 16'h0100;
                if (a == 14'd12402 || a == 14'd12403) w = 16'h0200;
                if (a == 14'd12501) w = 16'h0300;
            end
        endcase
        return w;
    endfunction

    always @(posedge clk) begin
        rd_data_a <= word(mem_addr_a);
        rd_data_b <= word(mem_addr_b);
    end

    // monitor: per-pass counters, compare on done rising
    int cyc = 0, rden = 0;
    bit prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            cyc = 0;
            rden = 0;
        end else begin
            if (busy) cyc++;
            if (mem_rd_en) rden++;
            if (done && !prev_done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sum", sum, e.sum);
                    chk("pair_count", pair_count, e.cnt);
                    chk("max_val", max_val, e.mx);
                    chk("max_addr", max_addr, e.mxa);
                    chk("err", err, e.err);
                    chk("busy_cycles", cyc, e.cyc);
                    chk("rd_en_count", rden, e.rden);
                end
                cyc = 0;
                rden = 0;
            end
        end
        prev_done = done;
    end

    function automatic exp_t mk(input int s, input int c, input int mx,
                                input int mxa, input int er,
                                input int cy, input int rd);
        exp_t e;
        e.sum = s; e.cnt = c; e.err = er; e.cyc = cy; e.rden = rd;
`ifdef PAIR_ACCUM_MAX_EN
        e.mx = mx; e.mxa = mxa;
`else
        e.mx = 0; e.mxa = 0;
`endif
        return e;
    endfunction

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_timeout", seen, 1);
    endtask

    // one pass: start cycle, then one pair per cycle up to END
    task automatic pass(input int first, input bit hold,
                        input int err_a, input int abort_k,
                        input bit lat);
        int k;
        @(posedge clk); #1;
        start = 1'b1;
        addr_a = 14'(first);
        addr_b = 14'(first + 1);
        @(posedge clk); #1;
        start = hold;
        k = 0;
        for (int a = first; a < END; a += 2) begin
            addr_a = 14'(a);
            addr_b = (a == err_a) ? 14'(a + 3) : 14'(a + 1);
            if (a == err_a) begin
                #1;
                chk("err_cycle_rd_en", mem_rd_en, 0);
            end
            if (k == abort_k) begin
                reset = 1'b0;
                #1;
                chk("abort_sum", sum, 0);
                chk("abort_cnt", pair_count, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_err", err, 0);
                chk("abort_max", max_val, 0);
                @(posedge clk); #1;
                reset = 1'b1;
                for (int j = 1; j <= 3; j++) begin
                    addr_a = 14'(a + 2 * j);
                    addr_b = 14'(a + 2 * j + 1);
                    @(negedge clk);
                    chk("post_abort_sum", sum, 0);
                    chk("post_abort_busy", busy, 0);
                    chk("post_abort_rd_en", mem_rd_en, 0);
                    @(posedge clk); #1;
                end
                return;
            end
            if (lat && k < 4) begin
                @(negedge clk);
                chk($sformatf("latency_cnt_%0d", k), pair_count,
                    (k >= 2) ? k - 1 : 0);
                chk($sformatf("latency_busy_%0d", k), busy, 1);
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        addr_a = 14'(END);
        addr_b = 14'(END + 1);
        wait_done();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        addr_a = 14'd12288;
        addr_b = 14'd12289;
        #1;
        chk("rst_sum", sum, 0);
        chk("rst_cnt", pair_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // full sweep: 4 x (0..255) = 130560, max 255 at 12543
        mode = 0;
        q.push_back(mk(130560, 512, 255, 12543, 0, 514, 512));
        pass(12288, 0, -1, -1, 1);

        // broken pair at 12500 drops 212 + 213
        q.push_back(mk(130135, 511, 255, 12543, 1, 514, 511));
        pass(12288, 0, 12500, -1, 0);

        // abort at pair 100, then a clean sweep
        pass(12288, 0, -1, 100, 0);
        q.push_back(mk(130560, 512, 255, 12543, 0, 514, 512));
        pass(12288, 0, -1, -1, 0);

        // start held through RUN is ignored
        q.push_back(mk(130560, 512, 255, 12543, 0, 514, 512));
        pass(12288, 1, -1, -1, 0);
        repeat (3) @(negedge clk);
        chk("done_hold_done", done, 1);
        chk("done_hold_sum", sum, 130560);
        chk("done_hold_cnt", pair_count, 512);

        // restart from DONE reproduces the same results
        q.push_back(mk(130560, 512, 255, 12543, 0, 514, 512));
        pass(12288, 0, -1, -1, 0);

        // equal 0xBEEF pair: A wins the tie
        mode = 1;
        q.push_back(mk(97758, 512, 'hBEEF, 12800, 0, 514, 512));
        pass(12288, 0, -1, -1, 0);

        // strict max, tie to even, B larger
        mode = 2;
        q.push_back(mk(2560, 512, 'h300, 12501, 0, 514, 512));
        pass(12288, 0, -1, -1, 0);

        // already at the end address
        mode = 0;
        q.push_back(mk(0, 0, 0, 0, 0, 2, 0));
        pass(END, 0, -1, -1, 0);

        repeat (2) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
